// File: rtl/alu_decoder_seq.sv
// ALU control decoder with a multi-cycle mul/div sequencer.
// Decode is purely combinational; the sequencer issues, stalls and writes HI/LO.
module alu_decoder_seq #(
    parameter int CTRL_W     = 4,
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_in,
    input  logic              flush,
    input  logic [1:0]        ALUOp,
    input  logic [5:0]        Funct,
    output logic [CTRL_W-1:0] ALUCtrl,
    output logic              illegal,
    output logic              md_start,
    output logic [1:0]        md_op,
    output logic              md_busy,
    output logic              stall,
    output logic              hilo_we
);

    localparam int MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    localparam logic [CNT_W-1:0] MUL_LD = CNT_W'(MUL_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LD = CNT_W'(DIV_CYCLES);

    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_XOR  = 4'b0011;
    localparam logic [3:0] OP_NOR  = 4'b1100;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_SLTU = 4'b1111;
    localparam logic [3:0] OP_SLL  = 4'b1000;
    localparam logic [3:0] OP_SRL  = 4'b1001;
    localparam logic [3:0] OP_SRA  = 4'b1010;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       md_op_q, md_op_d;

    logic       rtype;
    logic       mdreq;
    logic       hireq;
    logic [3:0] code;

    assign rtype = valid_in && (ALUOp == 2'b10);
    assign mdreq = rtype && (Funct[5:2] == 4'b0110);
    assign hireq = rtype && ((Funct == 6'b010000) || (Funct == 6'b010010));

    always_comb begin
        code    = OP_AND;
        illegal = 1'b0;
        case (ALUOp)
            2'b00: code = OP_ADD;
            2'b01: code = OP_SUB;
            2'b11: code = OP_OR;
            default: begin
                case (Funct)
                    6'b100000, 6'b100001: code = OP_ADD;
                    6'b100010, 6'b100011: code = OP_SUB;
                    6'b100100:            code = OP_AND;
                    6'b100101:            code = OP_OR;
                    6'b100110:            code = OP_XOR;
                    6'b100111:            code = OP_NOR;
                    6'b101010:            code = OP_SLT;
                    6'b101011:            code = OP_SLTU;
                    6'b000000:            code = OP_SLL;
                    6'b000010:            code = OP_SRL;
                    6'b000011:            code = OP_SRA;
                    // mul/div and mfhi/mflo pass through the adder path
                    6'b011000, 6'b011001, 6'b011010, 6'b011011,
                    6'b010000, 6'b010010: code = OP_ADD;
                    default: begin
                        code    = OP_AND;
                        illegal = valid_in;
                    end
                endcase
            end
        endcase
    end

    assign ALUCtrl = CTRL_W'(code);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        md_op_d  = md_op_q;
        md_start = 1'b0;
        hilo_we  = 1'b0;
        case (state_q)
            IDLE: begin
                if (mdreq && !flush) begin
                    md_start = 1'b1;
                    md_op_d  = Funct[1:0];
                    cnt_d    = Funct[1] ? DIV_LD : MUL_LD;
                    state_d  = BUSY;
                end
            end
            BUSY: begin
                if (flush) begin
                    state_d = IDLE;
                end else if (cnt_q == CNT_W'(1)) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DONE: begin
                // result is complete, so a flush here does not cancel the write
                hilo_we = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            md_op_q <= 2'b00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            md_op_q <= md_op_d;
        end
    end

    assign md_op   = md_op_q;
    assign md_busy = (state_q != IDLE);
    assign stall   = !flush && (((state_q == IDLE) && mdreq) ||
                                (state_q == BUSY) ||
                                ((state_q == DONE) && (mdreq || hireq)));

endmodule

// File: doc/alu_decoder_seq.md
Name: alu_decoder_seq

Overview:
Next-generation ALU control for the MIPS core. It decodes ALUOp/Funct to a parametrised-width ALUCtrl and extends the R-type set with xor, nor, sltu and shifts. It adds a sequencer for multi-cycle mult/multu/div/divu, which issues a start pulse to the mul/div unit, stalls the pipeline, and writes HI/LO on completion. It sits in the decode/execute boundary between the main controller, the ALU and the HI/LO unit.

Parameters:
CTRL_W, 4, ALUCtrl width; must be ≥4; codes below are zero-extended to CTRL_W.
MUL_CYCLES, 4, BUSY cycles for mult/multu; must be ≥1.
DIV_CYCLES, 32, BUSY cycles for div/divu; must be ≥1.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
valid_in  in  1  instruction in decode is valid.
flush  in  1  pipeline flush; aborts sequencer.
ALUOp  in  2  from main controller.
Funct  in  6  instr[5:0].
ALUCtrl  out  CTRL_W  ALU operation code (combinational).
illegal  out  1  unknown R-type funct (combinational).
md_start  out  1  one-cycle start pulse to mul/div unit.
md_op  out  2  latched op: 00 mult, 01 multu, 10 div, 11 divu.
md_busy  out  1  sequencer not IDLE.
stall  out  1  pipeline stall request (combinational).
hilo_we  out  1  HI/LO write enable, one cycle.

Behaviour:
- Clock and reset: one clock `clk`. Reset `rst_n` is asynchronous and active-low.
- ALUCtrl codes: add 0010, sub 0110, and 0000, or 0001, xor 0011, nor 1100, slt 0111, sltu 1111, sll 1000, srl 1001, sra 1010.
- Decode by ALUOp:
  - 00 → add.
  - 01 → sub.
  - 11 → or (ori).
  - 10 → decode by Funct.
- Funct decode (ALUOp=10):
  - 100000/100001 add; 100010/100011 sub; 100100 and; 100101 or; 100110 xor; 100111 nor; 101010 slt; 101011 sltu; 000000 sll; 000010 srl; 000011 sra.
  - 011000–011011 mul/div → ALUCtrl 0010, illegal=0.
  - 010000/010010 mfhi/mflo → ALUCtrl 0010, illegal=0.
  - Any other funct → ALUCtrl 0000, illegal=valid_in.
- ALUCtrl and illegal are purely combinational and independent of state and reset.
- Definitions:
  - mdreq = valid_in & ALUOp==10 & Funct[5:2]==0110.
  - hireq = valid_in & ALUOp==10 & Funct is mfhi/mflo.
- FSM states: IDLE, BUSY, DONE. Down-counter width $clog2(max(MUL_CYCLES,DIV_CYCLES)+1).
- IDLE:
  - If mdreq & ~flush: md_start=1 (combinational, this cycle).
  - On the same edge: md_op←Funct[1:0]; cnt←MUL_CYCLES if Funct[1]=0, else DIV_CYCLES; next state BUSY.
  - Otherwise stay in IDLE.
- BUSY:
  - If flush → IDLE.
  - Else if cnt==1 → DONE.
  - Else cnt←cnt−1.
  - mdreq while BUSY is not accepted; it is held by stall.
- DONE:
  - hilo_we=1 for exactly this cycle, then → IDLE unconditionally.
  - flush does not suppress hilo_we in DONE; the result is complete.
- Latency: issue at cycle T → BUSY T+1..T+N → DONE/hilo_we at T+N+1, where N is the MUL or DIV count.
- stall = ~flush & ((state==IDLE & mdreq) | state==BUSY | (state==DONE & (mdreq|hireq))).
  - mfhi/mflo are interlocked until HI/LO is written.
  - A back-to-back mul/div waits in DONE and issues from IDLE at T+N+2.
- md_busy = (state!=IDLE).
- Reset values: state IDLE, cnt 0, md_op 00, md_busy 0, md_start 0, hilo_we 0, stall 0 (with valid_in=0).
- Reset mid-operation: immediate return to IDLE and all registered outputs cleared; no hilo_we is generated.
- flush in IDLE suppresses md_start and stall.

Test Plan:
- Decode sweep: ALUOp=10, each funct listed above → exact ALUCtrl code, illegal=0. Funct=111111, valid_in=1 → ALUCtrl 0000, illegal=1. ALUOp=00/01/11 → 0010/0110/0001.
- mult (Funct 011000), MUL_CYCLES=4, issue at cycle 0:
  - md_start=1 and stall=1 at cycle 0; md_op=00.
  - md_busy=1 and stall=1 cycles 1–4.
  - hilo_we=1 only at cycle 5; stall=0 at cycle 5.
- divu (011011), DIV_CYCLES=32:
  - md_op=11; hilo_we at cycle 33.
  - mflo presented at cycle 10 → stall=1 through cycle 33, stall=0 at 34.
- Back-to-back mult then div, both valid: second held (stall=1) until IDLE at cycle 6. md_start for the div is asserted at cycle 6; hilo_we at cycles 5 and 39.
- flush at cycle 2 of BUSY → IDLE at cycle 3, md_busy=0, no hilo_we ever. flush with mdreq in IDLE → md_start=0, stall=0.
- rst_n low asynchronously mid-BUSY (between edges) → md_busy, hilo_we, md_op drop immediately to 0/0/00. After release, a new mult completes normally with 4-cycle latency.
